// File: rtl/complex_magnitude_squared_cal.sv
// Magnitude-squared of a signed complex sample, Re^2 + Im^2, on a 3-stage pipeline.
// The result width matches the square-root stage that consumes it.
module complex_magnitude_squared_cal #(
   parameter int DATA_WIDTH        = 36,
   parameter int OUTPUT_DATA_WIDTH = 72
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                dataInValid,
   input  logic signed [DATA_WIDTH-1:0]        dataInRe,
   input  logic signed [DATA_WIDTH-1:0]        dataInIm,
   output logic        [OUTPUT_DATA_WIDTH-1:0] dataOut,
   output logic                                dataOutValid
);

   localparam int SQ_W  = OUTPUT_DATA_WIDTH - 1;
   localparam int PAD_W = SQ_W - DATA_WIDTH;

   // The most-negative input maps to 2^(DATA_WIDTH-1), which still fits unsigned.
   function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] u;
      u = x;
      return u[DATA_WIDTH-1] ? (~u + 1'b1) : u;
   endfunction

   function automatic logic [SQ_W-1:0] square_u(input logic [DATA_WIDTH-1:0] a);
      logic [SQ_W-1:0] ext;
      ext = {{PAD_W{1'b0}}, a};
      return ext * ext;
   endfunction

   logic [DATA_WIDTH-1:0]        abs_re_p1_q, abs_re_p1_d;
   logic [DATA_WIDTH-1:0]        abs_im_p1_q, abs_im_p1_d;
   logic                         vld_p1_q,    vld_p1_d;
   logic [SQ_W-1:0]              sq_re_p2_q,  sq_re_p2_d;
   logic [SQ_W-1:0]              sq_im_p2_q,  sq_im_p2_d;
   logic                         vld_p2_q,    vld_p2_d;
   logic [OUTPUT_DATA_WIDTH-1:0] sum_p3_q,    sum_p3_d;
   logic                         vld_p3_q,    vld_p3_d;

   always_comb begin
      abs_re_p1_d = abs_re_p1_q;
      abs_im_p1_d = abs_im_p1_q;
      vld_p1_d    = vld_p1_q;
      sq_re_p2_d  = sq_re_p2_q;
      sq_im_p2_d  = sq_im_p2_q;
      vld_p2_d    = vld_p2_q;
      sum_p3_d    = sum_p3_q;
      vld_p3_d    = vld_p3_q;
      if (enable) begin
         // stage 1: absolute value
         abs_re_p1_d = abs_mag(dataInRe);
         abs_im_p1_d = abs_mag(dataInIm);
         vld_p1_d    = dataInValid;
         // stage 2: unsigned squares
         sq_re_p2_d  = square_u(abs_re_p1_q);
         sq_im_p2_d  = square_u(abs_im_p1_q);
         vld_p2_d    = vld_p1_q;
         // stage 3: sum, one guard bit absorbs the carry
         sum_p3_d    = {1'b0, sq_re_p2_q} + {1'b0, sq_im_p2_q};
         vld_p3_d    = vld_p2_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         abs_re_p1_q <= '0;
         abs_im_p1_q <= '0;
         vld_p1_q    <= 1'b0;
         sq_re_p2_q  <= '0;
         sq_im_p2_q  <= '0;
         vld_p2_q    <= 1'b0;
         sum_p3_q    <= '0;
         vld_p3_q    <= 1'b0;
      end else begin
         abs_re_p1_q <= abs_re_p1_d;
         abs_im_p1_q <= abs_im_p1_d;
         vld_p1_q    <= vld_p1_d;
         sq_re_p2_q  <= sq_re_p2_d;
         sq_im_p2_q  <= sq_im_p2_d;
         vld_p2_q    <= vld_p2_d;
         sum_p3_q    <= sum_p3_d;
         vld_p3_q    <= vld_p3_d;
      end
   end

   assign dataOut      = sum_p3_q;
   assign dataOutValid = vld_p3_q;

endmodule
